pe_result_collector: RTL and testbench

- Drain side of a chain of NUM_PE accumulate-PEs.
- Each PE pulses done for exactly one cycle; its 16-bit accumulated value is valid only in that cycle.
- This block does four things:
  - captures every lane's result on its done pulse;
  - requantizes it to 8 bits (rounding right-shift plus saturation);
  - serializes the results round-robin onto a valid/ready stream toward the output buffer;
  - counts results per tile and pulses tile_done.

---
 rtl/pe_result_collector.sv | 176 +++++++++++++++++
 tb/tb_pe_result_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// Drain side of an accumulate-PE chain: captures per-lane results on done,
// requantizes to 8 bits and serializes them round-robin onto a valid/ready stream.
module pe_result_collector #(
    parameter int NUM_PE = 4,
    parameter int LANE_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_results,
    input  logic [3:0]           shift,
    input  logic [NUM_PE-1:0]    pe_done,
    input  logic [16*NUM_PE-1:0] pe_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [LANE_W-1:0]    out_lane,
    output logic                 busy,
    output logic                 tile_done,
    output logic                 overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [15:0]         hold_q [NUM_PE];
    logic [15:0]         hold_d [NUM_PE];
    logic [NUM_PE-1:0]   hold_valid_q, hold_valid_d;
    logic [LANE_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [3:0]          shift_q, shift_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_data_q, out_data_d;
    logic [LANE_W-1:0]   out_lane_q, out_lane_d;
    logic                tile_done_q, tile_done_d;
    logic                overflow_q, overflow_d;

    logic                handshake;
    logic                slot_free;
    logic                grant_found;
    logic [LANE_W-1:0]   grant_idx;
    logic [LANE_W-1:0]   scan_idx;

    // Rounding right-shift in 17 bits, then clamp to the 8-bit output range.
    function automatic logic [7:0] requant_sat(input logic [15:0] v, input logic [3:0] sh);
        logic [16:0] sum;
        logic [16:0] r;
        if (sh == 4'd0) begin
            r = {1'b0, v};
        end else begin
            sum = {1'b0, v} + (17'd1 << (sh - 4'd1));
            r   = sum >> sh;
        end
        return (r > 17'd255) ? 8'hFF : r[7:0];
    endfunction

    assign handshake = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || handshake;

    // Round-robin search starting at the pointer, wrapping past NUM_PE-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            scan_idx = LANE_W'((int'(ptr_q) + k) % NUM_PE);
            if (!grant_found && hold_valid_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        num_d        = num_q;
        shift_d      = shift_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_lane_d   = out_lane_q;
        tile_done_d  = 1'b0;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    num_d      = num_results;
                    shift_d    = shift;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            RUN: begin
                if (handshake) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (handshake && (cnt_q == num_q - CNT_W'(1))) begin
                    // Tile complete: anything still held is dropped.
                    state_d      = IDLE;
                    tile_done_d  = 1'b1;
                    out_valid_d  = 1'b0;
                    hold_valid_d = '0;
                end else begin
                    if (slot_free) begin
                        out_valid_d = grant_found;
                        if (grant_found) begin
                            out_data_d              = requant_sat(hold_q[grant_idx], shift_q);
                            out_lane_d              = grant_idx;
                            hold_valid_d[grant_idx] = 1'b0;
                            ptr_d = (int'(grant_idx) == NUM_PE - 1) ? '0 : grant_idx + LANE_W'(1);
                        end
                    end
                    // A granted lane frees its hold this edge, so a new done may land in it.
                    for (int i = 0; i < NUM_PE; i++) begin
                        if (pe_done[i]) begin
                            if (hold_valid_d[i]) begin
                                overflow_d = 1'b1;
                            end else begin
                                hold_d[i]       = pe_value[16*i +: 16];
                                hold_valid_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_valid_q <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            num_q        <= '0;
            shift_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_lane_q   <= '0;
            tile_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            num_q        <= num_d;
            shift_q      <= shift_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_lane_q   <= out_lane_d;
            tile_done_q  <= tile_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign busy      = (state_q == RUN);
    assign tile_done = tile_done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector: latency, requantization, ordering,
// backpressure, overflow and mid-tile reset.
module tb_pe_result_collector;

    localparam int NUM_PE = 4;
    localparam int LANE_W = 2;
    localparam int CNT_W  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CNT_W-1:0]     num_results;
    logic [3:0]           shift;
    logic [NUM_PE-1:0]    pe_done;
    logic [16*NUM_PE-1:0] pe_value;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic [LANE_W-1:0]    out_lane;
    logic                 busy;
    logic                 tile_done;
    logic                 overflow;

    int checks = 0;
    int errors = 0;

    pe_result_collector #(.NUM_PE(NUM_PE), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_results(num_results),
        .shift      (shift),
        .pe_done    (pe_done),
        .pe_value   (pe_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .busy       (busy),
        .tile_done  (tile_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic [3:0] sh);
        start = 1'b1; num_results = n; shift = sh;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_results = '0; shift = '0;
        pe_done = '0; pe_value = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL reset_out_lane got %0d want 0", out_lane); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL reset_tile_done got %0b want 0", tile_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_single_lane();
        do_start(16'd1, 4'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
        out_ready = 1'b1;
        pe_done = 4'b0001; pe_value[15:0] = 16'h0042;
        tick();
        pe_done = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 8'h42) begin errors++; $display("FAIL single_data got %0h want 42", out_data); end
        checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL single_lane got %0d want 0", out_lane); end
        checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL single_early_done got %0b want 0", tile_done); end
        tick();
        checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL single_tile_done got %0b want 1", tile_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %0b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_fall got %0b want 0", out_valid); end
        tick();
        checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %0b want 0", tile_done); end
    endtask

    // Uses lane 3 so the round-robin pointer wraps back to 0 afterwards.
    task automatic test_rounding();
        logic [15:0] vals [3];
        logic [3:0]  shs  [3];
        logic [7:0]  exps [3];
        vals[0] = 16'h0018; shs[0] = 4'd4; exps[0] = 8'h02;
        vals[1] = 16'h0017; shs[1] = 4'd4; exps[1] = 8'h01;
        vals[2] = 16'h0100; shs[2] = 4'd0; exps[2] = 8'hFF;
        for (int t = 0; t < 3; t++) begin
            do_start(16'd1, shs[t]);
            out_ready = 1'b1;
            pe_done = 4'b1000; pe_value[63:48] = vals[t];
            tick();
            pe_done = '0;
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exps[t] || out_lane !== 2'd3) begin
                errors++;
                $display("FAIL round_%0d got v=%0b d=%0h l=%0d want v=1 d=%0h l=3", t, out_valid, out_data, out_lane, exps[t]);
            end
            tick();
            checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL round_done_%0d got %0b want 1", t, tile_done); end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exps [4];
        exps[0] = 8'd10; exps[1] = 8'd20; exps[2] = 8'd30; exps[3] = 8'd40;
        do_start(16'd4, 4'd0);
        out_ready = 1'b1;
        pe_done = 4'b1111;
        pe_value = {16'd40, 16'd30, 16'd20, 16'd10};
        tick();
        pe_done = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_lane !== LANE_W'(k) || out_data !== exps[k] || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL simul_%0d got v=%0b l=%0d d=%0d td=%0b want v=1 l=%0d d=%0d td=0", k, out_valid, out_lane, out_data, tile_done, k, exps[k]);
            end
        end
        tick();
        checks++; if (tile_done !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL simul_done got td=%0b v=%0b want td=1 v=0", tile_done, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [4];
        vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd50; vals[3] = 16'd60;
        do_start(16'd4, 4'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                pe_done = 4'(1 << i);
                pe_value[16*i +: 16] = vals[i];
            end else begin
                pe_done = '0;
            end
            tick();
            if (i >= 1) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'd100 || out_lane !== 2'd0) begin
                    errors++;
                    $display("FAIL stall_%0d got v=%0b d=%0d l=%0d want v=1 d=100 l=0", i, out_valid, out_data, out_lane);
                end
            end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_lane !== LANE_W'(k) || out_data !== vals[k][7:0]) begin
                errors++;
                $display("FAIL bp_drain_%0d got v=%0b l=%0d d=%0d want v=1 l=%0d d=%0d", k, out_valid, out_lane, out_data, k, vals[k]);
            end
        end
        tick();
        checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL bp_tile_done got %0b want 1", tile_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_overflow();
        do_start(16'd2, 4'd0);
        out_ready = 1'b0;
        pe_done = 4'b0011;
        pe_value[15:0] = 16'd7; pe_value[31:16] = 16'd5;
        tick();
        pe_done = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 8'd7 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_slot got v=%0b l=%0d d=%0d o=%0b want v=1 l=0 d=7 o=0", out_valid, out_lane, out_data, overflow);
        end
        pe_done = 4'b0010; pe_value[31:16] = 16'd9;
        tick();
        pe_done = '0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_data !== 8'd5) begin
            errors++; $display("FAIL ovf_kept got v=%0b l=%0d d=%0d want v=1 l=1 d=5", out_valid, out_lane, out_data);
        end
        tick();
        checks++; if (tile_done !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_end got td=%0b o=%0b want td=1 o=1", tile_done, overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_tile();
        do_start(16'd4, 4'd0);
        out_ready = 1'b0;
        pe_done = 4'b0111;
        pe_value = {16'd0, 16'd3, 16'd2, 16'd1};
        tick();
        pe_done = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== 8'd3) begin
            errors++; $display("FAIL mid_pre got v=%0b l=%0d d=%0d want v=1 l=2 d=3", out_valid, out_lane, out_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_lane !== 2'd0 || busy !== 1'b0 || tile_done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%0b d=%0h l=%0d b=%0b td=%0b o=%0b want all 0", out_valid, out_data, out_lane, busy, tile_done, overflow);
        end
        do_start(16'd1, 4'd0);
        out_ready = 1'b1;
        pe_done = 4'b0001; pe_value[15:0] = 16'h0033;
        tick();
        pe_done = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 8'h33 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_clean got v=%0b l=%0d d=%0h o=%0b want v=1 l=0 d=33 o=0", out_valid, out_lane, out_data, overflow);
        end
        tick();
        checks++; if (tile_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_clean_done got td=%0b b=%0b want td=1 b=0", tile_done, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_lane();
        test_rounding();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_reset_mid_tile();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
